// File: rtl/seq_det_pkg.sv
// Shared state type and default widths for the seq_det programmable pattern detector.
package seq_det_pkg;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_det_core.sv
// Serial history shift register, fill counter and length-masked pattern compare.
module seq_det_core #(
  parameter int PAT_W = seq_det_pkg::PAT_W,
  parameter int LEN_W = seq_det_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             overlap,
  input  logic             x,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_r;
  logic [PAT_W-1:0] hist_next_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W-1:0] fill_r;
  logic [LEN_W:0]   fill_inc_s;

  // Compare the history as it will look after this bit against the low len pattern bits
  always_comb begin
    hist_next_s = {hist_r[PAT_W-2:0], x};
    fill_inc_s  = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (i < int'(len));
    end
    if (shift_en) begin
      hit = (fill_inc_s >= {1'b0, len}) &&
            (((hist_next_s ^ pattern) & mask_s) == {PAT_W{1'b0}});
    end else begin
      hit = 1'b0;
    end
  end

  // History and fill; a non-overlapping match restarts the fill so old bits are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {LEN_W{1'b0}};
    end else if (shift_en) begin
      hist_r <= hist_next_s;
      if (hit && !overlap) begin
        fill_r <= {LEN_W{1'b0}};
      end else if (fill_r == FILL_MAX) begin
        fill_r <= fill_r;
      end else begin
        fill_r <= fill_inc_s[LEN_W-1:0];
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector controller (IDLE/RUN/DONE) with match counter and limit.
// Optional sticky limit interrupt enabled by defining SEQ_DET_IRQ_EN.
module seq_det_ctrl #(
  parameter int PAT_W = seq_det_pkg::PAT_W,
  parameter int LEN_W = seq_det_pkg::LEN_W,
  parameter int CNT_W = seq_det_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             stop,
  input  logic             x_valid,
  input  logic             x,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             irq,
  input  logic             irq_clr
);

  import seq_det_pkg::*;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_t           state_r;
  state_t           state_next_s;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic             overlap_r;
  logic [CNT_W-1:0] limit_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_inc_s;
  logic             y_r;
  logic             hit_s;
  logic             shift_en_s;
  logic             cfg_fire_s;
  logic             start_ok_s;
  logic             limit_hit_s;

  assign cfg_fire_s  = cfg_valid && cfg_ready;
  // A start alongside a config write is dropped so the new config is never run unchecked
  assign start_ok_s  = start && !cfg_valid && (state_r != RUN) &&
                       (len_r != {LEN_W{1'b0}}) && (len_r <= LEN_MAX);
  assign shift_en_s  = (state_r == RUN) && x_valid;
  assign count_inc_s = (count_r == {CNT_W{1'b1}}) ? count_r : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign limit_hit_s = hit_s && (limit_r != {CNT_W{1'b0}}) && (count_inc_s == limit_r);

  seq_det_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en_s),
    .clr      (start_ok_s),
    .overlap  (overlap_r),
    .x        (x),
    .len      (len_r),
    .pattern  (pattern_r),
    .hit      (hit_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; stop outranks the limit
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_ok_s) state_next_s = RUN;
        else            state_next_s = state_r;
      end
      RUN: begin
        if (stop)             state_next_s = IDLE;
        else if (limit_hit_s) state_next_s = DONE;
        else                  state_next_s = RUN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    cfg_ready = 1'b1;
    case (state_r)
      IDLE:    cfg_ready = 1'b1;
      RUN: begin
        busy      = 1'b1;
        cfg_ready = 1'b0;
      end
      DONE:    done = 1'b1;
      default: cfg_ready = 1'b1;
    endcase
  end

  // Config capture on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= {PAT_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      overlap_r <= 1'b0;
      limit_r   <= {CNT_W{1'b0}};
    end else if (cfg_fire_s) begin
      pattern_r <= cfg_pattern;
      len_r     <= cfg_len;
      overlap_r <= cfg_overlap;
      limit_r   <= cfg_limit;
    end else begin
      pattern_r <= pattern_r;
      len_r     <= len_r;
      overlap_r <= overlap_r;
      limit_r   <= limit_r;
    end
  end

  // Match pulse and saturating match counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      y_r <= hit_s;
      if (start_ok_s)  count_r <= {CNT_W{1'b0}};
      else if (hit_s)  count_r <= count_inc_s;
      else             count_r <= count_r;
    end
  end

  assign y           = y_r;
  assign match_count = count_r;

`ifdef SEQ_DET_IRQ_EN
  logic irq_r;

  // Sticky limit interrupt; a new set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else if ((state_r == RUN) && (state_next_s == DONE)) begin
      irq_r <= 1'b1;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign irq = irq_r;
`else
  logic unused_irq_clr_s;
  assign unused_irq_clr_s = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus randomized episodes vs a queue-based model.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_limit = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             x_valid = 1'b0;
  logic             x = 1'b0;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             irq;
  logic             irq_clr = 1'b0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_limit(cfg_limit), .start(start), .stop(stop), .x_valid(x_valid), .x(x),
    .y(y), .match_count(match_count), .busy(busy), .done(done), .irq(irq),
    .irq_clr(irq_clr)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: bits seen since start (or since last non-overlapping match)
  bit         m_run, m_done, m_y, m_irq, m_ovl;
  int         m_len, m_cnt, m_limit;
  logic [7:0] m_pat;
  bit         hist[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_y = 0; m_irq = 0; m_ovl = 0;
    m_len = 0; m_cnt = 0; m_limit = 0; m_pat = '0;
    hist.delete();
  endtask

  task automatic model_step();
    bit match, acc, go, to_done;
    acc = cfg_valid && !m_run;
    go = !m_run && start && !cfg_valid && (m_len >= 1) && (m_len <= PAT_W);
    match = 0;
    to_done = 0;
    if (m_run && x_valid) begin
      hist.push_back(x);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      if (hist.size() >= m_len) begin
        match = 1;
        for (int i = 0; i < m_len; i++)
          if (hist[hist.size() - 1 - i] != m_pat[i]) match = 0;
      end
      if (match && !m_ovl) hist.delete();
    end
    m_y = match;
    if (go) begin
      hist.delete();
      m_cnt = 0; m_run = 1; m_done = 0;
    end else if (m_run) begin
      if (match && m_cnt < CNT_MAX) m_cnt++;
      if (stop) m_run = 0;
      else if (match && m_limit != 0 && m_cnt == m_limit) begin
        m_run = 0; m_done = 1; to_done = 1;
      end
    end
`ifdef SEQ_DET_IRQ_EN
    if (to_done) m_irq = 1;
    else if (irq_clr) m_irq = 0;
`endif
    if (acc) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len);
      m_ovl = cfg_overlap; m_limit = int'(cfg_limit);
    end
  endtask

  task automatic check_all();
    check_eq("y", y, m_y);
    check_eq("match_count", match_count, m_cnt);
    check_eq("busy", busy, m_run);
    check_eq("done", done, m_done);
    check_eq("cfg_ready", cfg_ready, !m_run);
    check_eq("irq", irq, m_irq);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    cfg_valid = 0; start = 0; stop = 0; x_valid = 0; x = 0; irq_clr = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1;
    check_all();
  endtask

  task automatic do_cfg(input logic [7:0] pat, input int len, input bit ovl, input int lim);
    cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_limit = CNT_W'(lim);
    cfg_valid = 1; cyc(); cfg_valid = 0;
  endtask

  task automatic do_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic do_stop();
    stop = 1; cyc(); stop = 0;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    logic [31:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) begin
      x_valid = 1; x = b[i]; cyc();
    end
    x_valid = 0;
  endtask

  initial begin
    do_reset();
    check_eq("reset_cfg_ready", cfg_ready, 1);

    // 1011 non-overlap: only the first 1011 matches
    do_cfg(8'b1011, 4, 0, 0);
    do_start();
    send(32'b1011011, 7);
    check_eq("nonovl_count", match_count, 1);
    do_stop();
    check_eq("stop_holds_count", match_count, 1);

    // overlap: matches after bits 4 and 7
    do_cfg(8'b1011, 4, 1, 0);
    do_start();
    send(32'b1011011, 7);
    check_eq("ovl_count", match_count, 2);
    do_stop();

    // limit 2 reached at bit 7; bits 8-10 ignored
    do_cfg(8'b1011, 4, 1, 2);
    do_start();
    send(32'b1011011011, 10);
    check_eq("limit_done", done, 1);
    check_eq("limit_busy", busy, 0);
    check_eq("limit_count", match_count, 2);
`ifdef SEQ_DET_IRQ_EN
    check_eq("limit_irq", irq, 1);
`else
    check_eq("limit_irq", irq, 0);
`endif
    irq_clr = 1; cyc(); irq_clr = 0;
    check_eq("irq_cleared", irq, 0);

    // cfg during RUN is refused; stored 1011 stays in effect
    do_start();
    cfg_pattern = 8'hFF; cfg_len = 4'd2; cfg_valid = 1;
    cyc();
    check_eq("run_cfg_ready", cfg_ready, 0);
    cfg_valid = 0;
    send(32'b1011, 4);
    check_eq("cfg_kept_count", match_count, 1);
    do_stop();

    // illegal lengths and cfg+start collision leave the block idle
    do_cfg(8'b1, 0, 0, 0);
    do_start();
    check_eq("len0_idle", busy, 0);
    do_cfg(8'b1, 9, 0, 0);
    do_start();
    check_eq("len9_idle", busy, 0);
    cfg_pattern = 8'b1011; cfg_len = 4'd4; cfg_overlap = 0; cfg_limit = '0;
    cfg_valid = 1; start = 1; cyc(); cfg_valid = 0; start = 0;
    check_eq("cfg_start_idle", busy, 0);

    // valid gaps inside 1011
    do_start();
    x_valid = 1; x = 1; cyc();
    x_valid = 0; cyc();
    x_valid = 1; x = 0; cyc();
    x_valid = 0; cyc(); cyc();
    x_valid = 1; x = 1; cyc();
    x_valid = 1; x = 1; cyc();
    check_eq("gap_y", y, 1);
    x_valid = 0; cyc();
    check_eq("gap_y_drop", y, 0);
    check_eq("gap_count", match_count, 1);

    // reset mid-stream, then restart: stale 101 must not complete a match
    do_stop();
    do_start();
    send(32'b101, 3);
    do_reset();
    do_cfg(8'b1011, 4, 0, 0);
    do_start();
    send(32'b1, 1);
    check_eq("rst_restart_count", match_count, 0);
    do_stop();

    // counter saturation
    do_cfg(8'b1, 1, 0, 0);
    do_start();
    for (int i = 0; i < 300; i++) begin
      x_valid = 1; x = 1; cyc();
    end
    x_valid = 0;
    check_eq("sat_count", match_count, CNT_MAX);
    do_stop();

    // randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      int len;
      if ($urandom_range(0, 9) == 0) do_reset();
      len = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9) : int'($urandom_range(1, 4));
      do_cfg(8'($urandom), len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      do_start();
      for (int c = 0; c < 40; c++) begin
        x_valid = ($urandom_range(0, 3) != 0);
        x = 1'($urandom_range(0, 1));
        stop = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 19) == 0);
        irq_clr = ($urandom_range(0, 9) == 0);
        cfg_valid = ($urandom_range(0, 14) == 0);
        cfg_pattern = 8'($urandom);
        cfg_len = LEN_W'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
        cfg_limit = CNT_W'($urandom_range(0, 3));
        cyc();
      end
      idle_in();
      if (busy) do_stop();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Run-time programmable serial pattern detector controller for the FSM sequence-detector family.
- Accepts a pattern and length up to PAT_W bits over a valid/ready config port, then arms and runs detection on a qualified serial bit stream.
- Supports overlapping and non-overlapping matching, counts matches, and stops after a programmable match limit.
- Replaces hard-coded per-pattern FSMs (1011 etc.) with one sequenced block.

Parameters:
- PAT_W, 8: maximum pattern length in bits.
- LEN_W, 4: width of cfg_len; must hold PAT_W.
- CNT_W, 8: width of match counter and match limit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when cfg_valid&&cfg_ready.
- cfg_pattern  in  PAT_W  pattern; first-received bit is cfg_pattern[cfg_len-1].
- cfg_len  in  LEN_W  pattern length; legal values 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cfg_limit  in  CNT_W  match limit; 0 = unlimited.
- start  in  1  arm and run.
- stop  in  1  abort to IDLE.
- x_valid  in  1  qualifies x.
- x  in  1  serial data bit.
- y  out  1  Moore match pulse, registered.
- match_count  out  CNT_W  matches since last start.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- irq  out  1  sticky match-limit interrupt (see Optional Feature).
- irq_clr  in  1  clears irq.

Behaviour:
- Reset: state=IDLE; y=0; match_count=0; busy=0; done=0; irq=0; cfg_ready=1; stored cfg all 0; history and fill cleared.
- FSM states are IDLE, RUN, DONE.
- cfg_ready=1 in IDLE/DONE and 0 in RUN. Config is registered on handshake.
- If cfg_valid and start are asserted in the same cycle, cfg is accepted and start is ignored.
- IDLE/DONE -> RUN on start, only if stored len is in 1..PAT_W. Otherwise start is ignored.
- Entering RUN clears history, fill, match_count, y and done.
- RUN -> IDLE on stop; match_count is held. stop has priority over start and over the limit.
- start while in RUN is ignored.
- Detection: each x_valid cycle in RUN, x shifts into the LSB of a PAT_W history register and fill increments, saturating at PAT_W.
- A match is fill+1 >= len with the updated history[len-1:0] == pattern[len-1:0].
- On a match, y=1 for exactly one cycle, at the edge that samples the completing bit (Moore latency 1: visible the cycle after the bit is presented). match_count increments on the same edge, saturating at all-ones.
- Non-overlap: a match clears fill to 0 (history bits are retained but ignored).
- Overlap: fill is kept.
- Cycles with x_valid=0 leave history, fill and y unchanged except that y drops to 0.
- Limit: if limit!=0 and a match makes count equal to limit, the same edge moves the FSM RUN -> DONE. y still pulses; later x is ignored. busy=0 and done=1 in DONE.
- If stop coincides with the limit-reaching match, the match is counted, y pulses and the next state is IDLE.
- rst_n asserted mid-run returns everything to reset values immediately.

Optional Feature:
- Macro SEQ_DET_IRQ_EN.
- Defined: irq is set on the RUN -> DONE edge and held until irq_clr. If set and irq_clr coincide, set wins.
- Undefined: irq is tied 0, irq_clr is ignored, and no irq flop is built.

Decomposition:
- Package seq_det_pkg holds the state typedef (IDLE/RUN/DONE, 2-bit encoding) and default width constants PAT_W, LEN_W, CNT_W.
- Sub-module seq_det_core holds the history shift register, fill counter and masked compare. Its inputs are shift_en, clr, overlap, len and pattern; its output is the combinational hit. The controller registers y.

Test Plan:
- cfg pattern=1011, len=4, overlap=0, limit=0; start; x=1,0,1,1,0,1,1 all valid -> y pulses once, after the 4th bit; the final 011 gives no match; match_count=1.
- Same stream with overlap=1 -> y pulses after bits 4 and 7; match_count=2.
- overlap=1, limit=2, stream 1011011011 -> DONE after bit 7, busy=0, done=1, match_count=2, bits 8-10 ignored; irq=1 with SEQ_DET_IRQ_EN, 0 without.
- cfg_valid during RUN -> cfg_ready=0 and stored cfg unchanged. start with len=0 or len=9 -> stays IDLE. cfg and start in the same cycle -> cfg taken, remains IDLE.
- x_valid gaps inside 1011 (1,-,0,-,-,1,1) -> single y pulse. Drop rst_n mid-stream after 1,0,1, release, restart -> no spurious match, count=0.
- Pattern len=1, pattern=1, limit=0, 300 valid ones with CNT_W=8 -> match_count saturates at 255.
